// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared types and constants for the RAM port arbiter
package mem_port_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_RSP,
        WR_ACK,
        RMW_MRG,
        RMW_WR_ACK
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    // Wide enough for any supported lane count; users slice the low DATA_WIDTH/8 bits.
    localparam logic [63:0] MASK_FULL = '1;

endpackage

// File: rtl/mem_byte_merge.sv
// rtl/mem_byte_merge.sv - byte-lane merge of new data over an old word
module mem_byte_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] mask,
    output logic [DATA_WIDTH-1:0]   merged_data
);

    for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_lane
        assign merged_data[i*8 +: 8] = mask[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - IFU/LSU arbiter and sequencer for the single-port data RAM
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LSU_PRIORITY = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
    output logic                    o_ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_ifu_rsp_data,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic                    i_lsu_req_wr,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_req_mask,
    input  logic [DATA_WIDTH-1:0]   i_lsu_req_wdata,
    output logic                    o_lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_lsu_rsp_data,
    output logic                    o_ram_en,
    output logic                    o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [LANES-1:0]      FULL      = MASK_FULL[LANES-1:0];
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state;
    owner_t                  owner;
    owner_t                  last_grant;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [LANES-1:0]        req_mask;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH-1:0]   merged;

    logic                    grant_ifu;
    logic                    grant_lsu;
    logic                    acc_store;
    logic                    acc_full;
    logic [ADDR_WIDTH-1:0]   acc_addr;

    mem_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_data    (i_ram_rd_data),
        .new_data    (req_wdata),
        .mask        (req_mask),
        .merged_data (merged)
    );

    // Grants are gated by reset so every output drops the instant i_rst rises.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (i_ifu_req_valid && i_lsu_req_valid) begin
                if (LSU_PRIORITY != 0 || last_grant == OWN_IFU) grant_lsu = 1'b1;
                else                                            grant_ifu = 1'b1;
            end else begin
                grant_ifu = i_ifu_req_valid;
                grant_lsu = i_lsu_req_valid;
            end
        end
    end

    assign acc_store = grant_lsu && i_lsu_req_wr;
    assign acc_full  = (i_lsu_req_mask == FULL);
    assign acc_addr  = (grant_lsu ? i_lsu_req_addr : i_ifu_req_addr) & WORD_MASK;

    always_comb begin
        o_ifu_req_ready = grant_ifu;
        o_lsu_req_ready = grant_lsu;
        o_ifu_rsp_valid = 1'b0;
        o_ifu_rsp_data  = '0;
        o_lsu_rsp_valid = 1'b0;
        o_lsu_rsp_data  = '0;
        o_ram_en        = 1'b0;
        o_ram_wr_en     = 1'b0;
        o_ram_addr      = '0;
        o_ram_wr_data   = '0;
        case (state)
            IDLE: begin
                // Zero-mask stores touch nothing; partial stores start with a read.
                if (grant_ifu || grant_lsu) begin
                    if (!acc_store || i_lsu_req_mask != '0) begin
                        o_ram_en   = 1'b1;
                        o_ram_addr = acc_addr;
                    end
                    if (acc_store && acc_full) begin
                        o_ram_wr_en   = 1'b1;
                        o_ram_wr_data = i_lsu_req_wdata;
                    end
                end
            end
            RD_RSP: begin
                if (owner == OWN_IFU) begin
                    o_ifu_rsp_valid = 1'b1;
                    o_ifu_rsp_data  = i_ram_rd_data;
                end else begin
                    o_lsu_rsp_valid = 1'b1;
                    o_lsu_rsp_data  = i_ram_rd_data;
                end
            end
            RMW_MRG: begin
                o_ram_en      = 1'b1;
                o_ram_wr_en   = 1'b1;
                o_ram_addr    = req_addr;
                o_ram_wr_data = merged;
            end
            WR_ACK, RMW_WR_ACK: o_lsu_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            req_addr   <= '0;
            req_mask   <= '0;
            req_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
                        last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
                        req_addr   <= acc_addr;
                        req_mask   <= i_lsu_req_mask;
                        req_wdata  <= i_lsu_req_wdata;
                        if (!acc_store)                           state <= RD_RSP;
                        else if (acc_full || i_lsu_req_mask == '0) state <= WR_ACK;
                        else                                      state <= RMW_MRG;
                    end
                end
                RMW_MRG: state <= RMW_WR_ACK;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - self-checking bench for mem_port_arb
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_valid = 1'b0, ifu_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr = '0, ifu_rsp_data;
    logic        lsu_valid = 1'b0, lsu_ready, lsu_wr = 1'b0, lsu_rsp_valid;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rsp_data;
    logic [3:0]  lsu_mask = '0;
    logic        ram_en, ram_wr_en;
    logic [31:0] ram_addr, ram_wr_data, ram_rd_data;

    logic        p_ifu_valid = 1'b0, p_lsu_valid = 1'b0;
    logic        p_ifu_ready, p_lsu_ready, p_ifu_rsp_valid, p_lsu_rsp_valid;
    logic        p_ram_en, p_ram_wr_en;
    logic [31:0] p_ifu_rsp_data, p_lsu_rsp_data, p_ram_addr, p_ram_wr_data;
    logic [31:0] p_rd_data = 32'h5555AAAA;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LSU_PRIORITY(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ifu_req_valid(ifu_valid), .o_ifu_req_ready(ifu_ready), .i_ifu_req_addr(ifu_addr),
        .o_ifu_rsp_valid(ifu_rsp_valid), .o_ifu_rsp_data(ifu_rsp_data),
        .i_lsu_req_valid(lsu_valid), .o_lsu_req_ready(lsu_ready), .i_lsu_req_wr(lsu_wr),
        .i_lsu_req_addr(lsu_addr), .i_lsu_req_mask(lsu_mask), .i_lsu_req_wdata(lsu_wdata),
        .o_lsu_rsp_valid(lsu_rsp_valid), .o_lsu_rsp_data(lsu_rsp_data),
        .o_ram_en(ram_en), .o_ram_wr_en(ram_wr_en), .o_ram_addr(ram_addr),
        .o_ram_wr_data(ram_wr_data), .i_ram_rd_data(ram_rd_data)
    );

    mem_port_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LSU_PRIORITY(1)) dut_pri (
        .i_clk(clk), .i_rst(rst),
        .i_ifu_req_valid(p_ifu_valid), .o_ifu_req_ready(p_ifu_ready), .i_ifu_req_addr(ifu_addr),
        .o_ifu_rsp_valid(p_ifu_rsp_valid), .o_ifu_rsp_data(p_ifu_rsp_data),
        .i_lsu_req_valid(p_lsu_valid), .o_lsu_req_ready(p_lsu_ready), .i_lsu_req_wr(lsu_wr),
        .i_lsu_req_addr(lsu_addr), .i_lsu_req_mask(lsu_mask), .i_lsu_req_wdata(lsu_wdata),
        .o_lsu_rsp_valid(p_lsu_rsp_valid), .o_lsu_rsp_data(p_lsu_rsp_data),
        .o_ram_en(p_ram_en), .o_ram_wr_en(p_ram_wr_en), .o_ram_addr(p_ram_addr),
        .o_ram_wr_data(p_ram_wr_data), .i_ram_rd_data(p_rd_data)
    );

    // RAM environment: 128 words covering 0x80000000..0x800001FF
    logic [31:0] env_mem [128];
    logic [31:0] ref_mem [128];

    always @(posedge clk) begin
        if (ram_en && ram_wr_en) env_mem[ram_addr[8:2]] <= ram_wr_data;
        if (ram_en && !ram_wr_en) ram_rd_data <= env_mem[ram_addr[8:2]];
        else                      ram_rd_data <= $urandom;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one expected-output record per cycle, scheduled at acceptance
    typedef struct {
        logic        ifu_rdy, lsu_rdy, ifu_v, lsu_v, ram_en, ram_wr;
        logic [31:0] ifu_d, lsu_d, ram_addr, ram_wd;
    } rec_t;

    rec_t sched[$];
    bit   last_lsu = 1'b1;
    bit   ifu_taken = 1'b0, lsu_taken = 1'b0;

    function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
        logic [31:0] res = 0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] lane = 32'hFF << (8 * i);
            res = res | ((m[i] ? new_w : old_w) & lane);
        end
        return res;
    endfunction

    task automatic plan();
        rec_t r0, r1, r2;
        bit gi, gl, three;
        logic [31:0] w;
        int idx;
        r0 = '{default: '0};
        r1 = r0;
        r2 = r0;
        three = 1'b0;
        gi = ifu_valid && (!lsu_valid || last_lsu);
        gl = lsu_valid && !gi;
        if (gi) begin
            w = ifu_addr & ~32'd3;
            idx = (w >> 2) & 127;
            r0.ifu_rdy = 1; r0.ram_en = 1; r0.ram_addr = w;
            r1.ifu_v = 1; r1.ifu_d = ref_mem[idx];
            last_lsu = 0; ifu_taken = 1;
        end else if (gl) begin
            w = lsu_addr & ~32'd3;
            idx = (w >> 2) & 127;
            r0.lsu_rdy = 1;
            last_lsu = 1; lsu_taken = 1;
            if (!lsu_wr) begin
                r0.ram_en = 1; r0.ram_addr = w;
                r1.lsu_v = 1; r1.lsu_d = ref_mem[idx];
            end else if (lsu_mask == 4'hF) begin
                r0.ram_en = 1; r0.ram_wr = 1; r0.ram_addr = w; r0.ram_wd = lsu_wdata;
                r1.lsu_v = 1;
            end else if (lsu_mask == 4'h0) begin
                r1.lsu_v = 1;
            end else begin
                r0.ram_en = 1; r0.ram_addr = w;
                r1.ram_en = 1; r1.ram_wr = 1; r1.ram_addr = w;
                r1.ram_wd = merge_ref(ref_mem[idx], lsu_wdata, lsu_mask);
                r2.lsu_v = 1;
                three = 1'b1;
            end
        end
        sched.push_back(r0);
        if (gi || gl) sched.push_back(r1);
        if (three) sched.push_back(r2);
    endtask

    always @(negedge clk) begin
        rec_t r;
        r = '{default: '0};
        if (rst) begin
            sched.delete();
            last_lsu = 1'b1;
            ifu_taken = 1'b0;
            lsu_taken = 1'b0;
        end else begin
            ifu_taken = 1'b0;
            lsu_taken = 1'b0;
            if (sched.size() == 0) plan();
            r = sched.pop_front();
        end
        chk("m_ifu_ready", ifu_ready, r.ifu_rdy);
        chk("m_lsu_ready", lsu_ready, r.lsu_rdy);
        chk("m_ifu_rsp_valid", ifu_rsp_valid, r.ifu_v);
        chk("m_ifu_rsp_data", ifu_rsp_data, r.ifu_d);
        chk("m_lsu_rsp_valid", lsu_rsp_valid, r.lsu_v);
        chk("m_lsu_rsp_data", lsu_rsp_data, r.lsu_d);
        chk("m_ram_en", ram_en, r.ram_en);
        chk("m_ram_wr_en", ram_wr_en, r.ram_wr);
        chk("m_ram_addr", ram_addr, r.ram_addr);
        chk("m_ram_wr_data", ram_wr_data, r.ram_wd);
        if (!rst && r.ram_en && r.ram_wr) ref_mem[(r.ram_addr >> 2) & 127] = r.ram_wd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        step(); rst = 1'b1;
        step(); rst = 1'b0;
    endtask

    initial begin
        int grants[$];
        int pri_lsu;
        for (int i = 0; i < 128; i++) begin
            env_mem[i] = (32'h9E3779B9 * i) ^ 32'h00C0FFEE;
            ref_mem[i] = env_mem[i];
        end
        env_mem[0]  = 32'hCAFE0000; ref_mem[0]  = 32'hCAFE0000;
        env_mem[1]  = 32'h00000413; ref_mem[1]  = 32'h00000413;
        env_mem[64] = 32'h11223344; ref_mem[64] = 32'h11223344;

        probe();
        chk("reset_ram_en", ram_en, 0);
        chk("reset_lsu_rsp", lsu_rsp_valid, 0);
        step(); rst = 1'b0;

        // IFU-only read
        step(); ifu_valid = 1; ifu_addr = 32'h80000004;
        probe();
        chk("ifu_rd_ready", ifu_ready, 1);
        chk("ifu_rd_ram_en", ram_en, 1);
        chk("ifu_rd_ram_addr", ram_addr, 32'h80000004);
        step();
        probe();
        chk("ifu_rd_rsp_valid", ifu_rsp_valid, 1);
        chk("ifu_rd_rsp_data", ifu_rsp_data, 32'h00000413);
        chk("ifu_rd_ready_t1", ifu_ready, 0);
        step();
        probe();
        chk("ifu_rd_ready_t2", ifu_ready, 1);
        step(); ifu_valid = 0;

        // Both loads valid from reset
        rst_pulse();
        step(); ifu_valid = 1; ifu_addr = 32'h80000000;
        lsu_valid = 1; lsu_wr = 0; lsu_addr = 32'h80000100;
        probe();
        chk("tie_ifu_ready", ifu_ready, 1);
        chk("tie_lsu_ready", lsu_ready, 0);
        step(); ifu_valid = 0;
        probe();
        chk("tie_ifu_rsp", ifu_rsp_valid, 1);
        chk("tie_ifu_data", ifu_rsp_data, 32'hCAFE0000);
        chk("tie_lsu_rsp_t1", lsu_rsp_valid, 0);
        step();
        probe();
        chk("tie_lsu_ready_t2", lsu_ready, 1);
        step(); lsu_valid = 0;
        probe();
        chk("tie_lsu_rsp", lsu_rsp_valid, 1);
        chk("tie_lsu_data", lsu_rsp_data, 32'h11223344);
        chk("tie_ifu_rsp_t3", ifu_rsp_valid, 0);

        // Byte store via read-modify-write
        step(); lsu_valid = 1; lsu_wr = 1; lsu_addr = 32'h80000102;
        lsu_mask = 4'b0100; lsu_wdata = 32'h00AB0000;
        probe();
        chk("sb_rd_en", ram_en, 1);
        chk("sb_rd_wr", ram_wr_en, 0);
        chk("sb_rd_addr", ram_addr, 32'h80000100);
        step(); lsu_valid = 0;
        probe();
        chk("sb_wr_wr", ram_wr_en, 1);
        chk("sb_wr_data", ram_wr_data, 32'h11AB3344);
        step();
        probe();
        chk("sb_ack", lsu_rsp_valid, 1);
        chk("sb_ack_data", lsu_rsp_data, 0);

        // Full-word store, then zero-mask store
        step(); lsu_valid = 1; lsu_addr = 32'h80000008; lsu_mask = 4'hF; lsu_wdata = 32'hDEADBEEF;
        probe();
        chk("sw_wr", ram_wr_en, 1);
        chk("sw_data", ram_wr_data, 32'hDEADBEEF);
        step(); lsu_valid = 0;
        probe();
        chk("sw_ack", lsu_rsp_valid, 1);
        chk("sw_ack_ram_en", ram_en, 0);
        step(); lsu_valid = 1; lsu_addr = 32'h8000000C; lsu_mask = 4'h0;
        probe();
        chk("z_ready", lsu_ready, 1);
        chk("z_ram_en", ram_en, 0);
        step(); lsu_valid = 0;
        probe();
        chk("z_ack", lsu_rsp_valid, 1);

        // Asynchronous reset during the merge-write cycle
        step(); lsu_valid = 1; lsu_addr = 32'h80000100; lsu_mask = 4'b0001; lsu_wdata = 32'h000000EE;
        probe();
        chk("rr_ready", lsu_ready, 1);
        step(); lsu_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("rr_ram_en", ram_en, 0);
        chk("rr_ram_wr", ram_wr_en, 0);
        chk("rr_wr_data", ram_wr_data, 0);
        step(); rst = 1'b0;
        probe();
        chk("rr_no_ack", lsu_rsp_valid, 0);
        chk("rr_mem_kept", env_mem[64], 32'h11AB3344);
        step(); ifu_valid = 1; ifu_addr = 32'h80000010;
        probe();
        chk("rr_ifu_ready", ifu_ready, 1);
        step(); ifu_valid = 0;
        probe();
        chk("rr_ifu_rsp", ifu_rsp_valid, 1);

        // Round-robin alternation with both held valid
        rst_pulse();
        step(); ifu_valid = 1; ifu_addr = 32'h80000020;
        lsu_valid = 1; lsu_wr = 0; lsu_addr = 32'h80000024;
        for (int c = 0; c < 10; c++) begin
            probe();
            if (ifu_ready) grants.push_back(0);
            if (lsu_ready) grants.push_back(1);
            if (c < 9) step();
        end
        step(); ifu_valid = 0; lsu_valid = 0;
        chk("rr_grant_count", grants.size(), 5);
        for (int k = 0; k < grants.size(); k++) chk("rr_grant_order", grants[k], k % 2);

        // LSU priority instance
        step(); p_ifu_valid = 1; p_lsu_valid = 1; lsu_wr = 0;
        pri_lsu = 0;
        for (int c = 0; c < 10; c++) begin
            probe();
            chk("pri_ifu_ready", p_ifu_ready, 0);
            chk("pri_ifu_rsp", p_ifu_rsp_valid, 0);
            if (p_lsu_ready) pri_lsu++;
            if (c < 9) step();
        end
        step(); p_ifu_valid = 0; p_lsu_valid = 0;
        chk("pri_lsu_grants", pri_lsu, 5);

        // Randomized traffic, with occasional mid-cycle resets
        for (int c = 0; c < 800; c++) begin
            step();
            rst = 1'b0;
            if (!ifu_valid || ifu_taken) begin
                ifu_valid = ($urandom_range(0, 2) != 0);
                ifu_addr  = 32'h80000000 | ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            end
            if (!lsu_valid || lsu_taken) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_wr    = $urandom_range(0, 1);
                lsu_addr  = 32'h80000000 | ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
                lsu_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       lsu_mask = 4'h0;
                    1:       lsu_mask = 4'hF;
                    default: lsu_mask = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
            end
        end
        step(); rst = 1'b0; ifu_valid = 0; lsu_valid = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
